// File: rtl/bus_gen_arbiter.sv
// bus_gen_arbiter: shared-bus generator with a round-robin arbiter.
// It moves one packet per transfer from a pending source FIFO into the
// destination FIFO(s) named by the packet's top 8-bit ID. Broadcast, self-send
// and out-of-range (dropped) IDs are all handled.
//
// Ports:
//   clk     - system clock, rising edge
//   reset   - synchronous, active-low reset
//   pndng   - per-device "FIFO not empty" flags
//   pop     - one-hot pop strobe to the granted source FIFO
//   D_pop   - head packet of each FIFO, lane i = [i*pckg_sz +: pckg_sz]
//   push    - push strobe(s) to the destination FIFO(s)
//   D_push  - captured bus packet, replicated on every lane
module bus_gen_arbiter #(
  parameter int unsigned pckg_sz   = 16,
  parameter int unsigned drvrs     = 8,
  parameter logic [7:0]  broadcast = 8'hFF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [drvrs-1:0]         pndng,
  output logic [drvrs-1:0]         pop,
  input  logic [drvrs*pckg_sz-1:0] D_pop,
  output logic [drvrs-1:0]         push,
  output logic [drvrs*pckg_sz-1:0] D_push
);

  localparam int unsigned IdxW = (drvrs > 1) ? $clog2(drvrs) : 1;
  localparam int unsigned IdW  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    PUSH = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     grant_q, grant_d;
  logic [IdxW-1:0]     last_q, last_d;
  logic [pckg_sz-1:0]  pkt_q, pkt_d;
  logic [drvrs-1:0]    pop_q, pop_d;
  logic [drvrs-1:0]    push_q, push_d;

  logic                found_c;
  logic [IdxW-1:0]     sel_c;
  int unsigned         rr_idx_c;
  logic [drvrs-1:0]    sel_oh_c;
  logic [drvrs-1:0]    grant_oh_c;
  logic [pckg_sz-1:0]  lane_c;
  logic [IdW-1:0]      dest_c;
  logic [drvrs-1:0]    mask_c;

  // Round-robin pick: first pending device after the last one served, wrapping modulo drvrs
  always_comb begin
    found_c  = 1'b0;
    sel_c    = '0;
    rr_idx_c = 0;
    for (int unsigned k = 1; k <= drvrs; k++) begin
      rr_idx_c = (32'(last_q) + k) % drvrs;
      if (!found_c && pndng[IdxW'(rr_idx_c)]) begin
        found_c = 1'b1;
        sel_c   = IdxW'(rr_idx_c);
      end
    end
  end

  // One-hot forms of the new selection and the current grant
  always_comb begin
    sel_oh_c           = '0;
    sel_oh_c[sel_c]    = 1'b1;
    grant_oh_c         = '0;
    grant_oh_c[grant_q] = 1'b1;
  end

  // Head packet of the granted FIFO and its destination field
  always_comb begin
    lane_c = D_pop[32'(grant_q) * pckg_sz +: pckg_sz];
    dest_c = lane_c[pckg_sz-1 -: IdW];
  end

  // Destination mask; broadcast skips the source, out-of-range IDs are dropped
  always_comb begin
    mask_c = '0;
    if (dest_c == broadcast) begin
      mask_c = ~grant_oh_c;
    end else if (32'(dest_c) < drvrs) begin
      mask_c[IdxW'(dest_c)] = 1'b1;
    end
  end

  // Next-state and registered-output logic. Strobes are precomputed one cycle
  // ahead so pop is high throughout POP and push throughout PUSH.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    pkt_d   = pkt_q;
    pop_d   = '0;
    push_d  = '0;
    case (state_q)
      IDLE: begin
        if (found_c) begin
          grant_d = sel_c;
          pop_d   = sel_oh_c;
          state_d = POP;
        end
      end
      POP: begin
        // Packet is captured here, so pndng changes during POP have no effect
        last_d  = grant_q;
        pkt_d   = lane_c;
        push_d  = mask_c;
        state_d = PUSH;
      end
      PUSH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset aborts any transfer and discards the captured packet
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IdxW'(drvrs - 1);
      pkt_q   <= '0;
      pop_q   <= '0;
      push_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      pkt_q   <= pkt_d;
      pop_q   <= pop_d;
      push_q  <= push_d;
    end
  end

  assign pop    = pop_q;
  assign push   = push_q;
  assign D_push = {drvrs{pkt_q}};

endmodule

// File: tb/tb_bus_gen_arbiter.sv
// Testbench for bus_gen_arbiter: FIFO models drive the source side, and a
// transaction-level reference model predicts the strobes and bus value for
// every cycle into a scoreboard. A negedge monitor consumes the scoreboard.
module tb_bus_gen_arbiter;

  localparam int N = 8;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   pndng;
  logic [N-1:0]   pop;
  logic [N*W-1:0] D_pop;
  logic [N-1:0]   push;
  logic [N*W-1:0] D_push;

  bus_gen_arbiter #(.pckg_sz(W), .drvrs(N), .broadcast(8'hFF)) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .pop(pop),
    .D_pop(D_pop), .push(push), .D_push(D_push)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc_n  = 0;

  // Per-device FIFO contents, pending pops, and per-device pndng enable
  logic [W-1:0] fifo [N][$];
  logic [N-1:0] rm_pend = '0;
  logic [N-1:0] keep = '1;

  typedef struct packed {
    logic [N-1:0] p;
    logic [N-1:0] s;
    logic [W-1:0] b;
  } exp_t;

  exp_t sb[$];

  // Reference rules
  function automatic int rr_pick(logic [N-1:0] req, int lst);
    for (int k = 1; k <= N; k++) begin
      if (req[(lst + k) % N]) return (lst + k) % N;
    end
    return 0;
  endfunction

  function automatic logic [N-1:0] exp_mask(logic [W-1:0] p, int src);
    int           d;
    logic [N-1:0] m;
    d = int'(p[W-1 -: 8]);
    m = '0;
    if (d == 255) begin
      m = '1;
      m[src] = 1'b0;
    end else if (d < N) begin
      m[d] = 1'b1;
    end
    return m;
  endfunction

  // Reference model: a transfer occupies the arbiter for three edges
  int           busy = 0;
  int           last = N - 1;
  int           g;
  logic         pv = 1'b0;
  logic [N-1:0] pmask;
  logic [W-1:0] ppkt;
  logic [W-1:0] e_bus = '0;

  always @(posedge clk) begin
    exp_t e;
    cyc_n++;
    e.p = '0;
    e.s = '0;
    if (!reset) begin
      busy  = 0;
      last  = N - 1;
      pv    = 1'b0;
      e_bus = '0;
    end else begin
      if (pv) begin
        e.s   = pmask;
        e_bus = ppkt;
        pv    = 1'b0;
      end
      if (busy > 0) begin
        busy--;
      end else if (pndng != '0) begin
        g      = rr_pick(pndng, last);
        last   = g;
        e.p[g] = 1'b1;
        ppkt   = fifo[g][0];
        pmask  = exp_mask(ppkt, g);
        pv     = 1'b1;
        busy   = 2;
      end
    end
    e.b = e_bus;
    sb.push_back(e);
  end

  task automatic check(string nm, logic [N*W-1:0] act, logic [N*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc_n, act, exp);
    end
  endtask

  // Monitor: compare every cycle's outputs against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("pop", N*W'(pop), N*W'(e.p));
      check("push", N*W'(push), N*W'(e.s));
      check("D_push", D_push, {N{e.b}});
    end
  end

  // Present FIFO heads and pending flags to the DUT
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      pndng[i]       = (fifo[i].size() > 0) && keep[i];
      D_pop[i*W +: W] = (fifo[i].size() > 0) ? fifo[i][0] : W'($urandom);
    end
  endtask

  // Advance n cycles; a FIFO drops its head after the cycle its pop was high
  task automatic cyc(int n);
    repeat (n) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (rm_pend[i] && fifo[i].size() > 0) void'(fifo[i].pop_front());
      end
      rm_pend = pop;
      drive();
    end
  endtask

  initial begin
    int           t;
    int           left;
    logic [7:0]   dest;
    reset = 1'b0;
    pndng = '0;
    D_pop = '0;

    // Reset held with random pending flags
    for (int i = 0; i < N; i++) fifo[i].push_back(W'($urandom));
    for (int r = 0; r < 3; r++) begin
      keep = N'($urandom);
      drive();
      cyc(1);
    end
    for (int i = 0; i < N; i++) fifo[i].delete();
    rm_pend = '0;
    keep    = '1;
    fifo[0].push_back(16'h0312);
    reset = 1'b1;
    drive();
    cyc(6);

    // Unicast 2 -> 5
    fifo[2].push_back(16'h0512);
    drive();
    cyc(6);

    // Broadcast from 3
    fifo[3].push_back(16'hFFAB);
    drive();
    cyc(6);

    // Round-robin from a fresh reset, all devices pending
    reset = 1'b0;
    drive();
    cyc(1);
    reset = 1'b1;
    for (int i = 0; i < N; i++) begin
      fifo[i].push_back(16'h0000);
      fifo[i].push_back(16'h0000);
    end
    drive();
    cyc(60);

    // Out-of-range destination, then a normal requester
    fifo[1].push_back(16'h0A00);
    fifo[4].push_back(16'h0455);
    drive();
    cyc(12);

    // Reset during the POP cycle
    fifo[5].push_back(16'h0155);
    drive();
    t = 0;
    while (pop == '0 && t < 10) begin
      cyc(1);
      t++;
    end
    if (pop == '0) begin
      checks++;
      errors++;
      $display("FAIL pop_timeout cycle %0d: got no pop expected a pop within 10 cycles", cyc_n);
    end
    reset = 1'b0;
    fifo[0].push_back(16'h0301);
    fifo[6].push_back(16'h0002);
    drive();
    cyc(1);
    reset = 1'b1;
    drive();
    cyc(12);

    // Randomized traffic with pending-flag glitches and occasional reset
    for (int r = 0; r < 500; r++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0, 1:    dest = 8'($urandom_range(0, N - 1));
          2:       dest = 8'hFF;
          default: dest = 8'($urandom_range(N, 254));
        endcase
        fifo[$urandom_range(0, N - 1)].push_back({dest, 8'($urandom)});
      end
      for (int i = 0; i < N; i++) keep[i] = ($urandom_range(0, 7) != 0);
      reset = ($urandom_range(0, 63) != 0);
      drive();
      cyc(1);
    end

    // Drain everything
    keep  = '1;
    reset = 1'b1;
    drive();
    cyc(200);
    left = 0;
    for (int i = 0; i < N; i++) left += fifo[i].size();
    checks++;
    if (left != 0) begin
      errors++;
      $display("FAIL drain cycle %0d: got %0d packets left expected 0", cyc_n, left);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
